// File: rtl/fuzzy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fuzzy_pkg
//  Brief    : Shared widths, default output-set centroids and the
//             defuzzifier FSM state type for the type-2 fuzzy pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package fuzzy_pkg;

   // Membership-grade width, denominator and numerator accumulator widths
   localparam int W_MF  = 8;
   localparam int W_DEN = 11;
   localparam int W_NUM = 19;

   // Default output-set centroids (0..255 scale), shared with the rule base
   localparam logic [W_MF-1:0] C1_PADRAO    = 8'd32;
   localparam logic [W_MF-1:0] C2_PADRAO    = 8'd128;
   localparam logic [W_MF-1:0] C3_PADRAO    = 8'd224;
   localparam logic [W_MF-1:0] SAIDA_PADRAO_DEF = 8'd128;

   // Defuzzifier control states
   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      ACUM   = 2'd1,
      DIVIDE = 2'd2,
      FIM    = 2'd3
   } defuz_estado_t;

endpackage

`default_nettype wire

// File: rtl/divisor_serial.sv
`default_nettype none
// ============================================================================
//  Module   : divisor_serial
//  Brief    : Serial restoring divider, one quotient bit per clock, MSB first.
//             A start pulse loads the operands; done pulses one cycle after
//             the last iteration. Remainder is kept internally only.
//  Revision : 1.0 - initial release
// ============================================================================
module divisor_serial #(
   parameter int W_DVD = 19,
   parameter int W_DVS = 11
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W_DVD-1:0] dividendo,
   input  logic [W_DVS-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [W_DVD-1:0] quociente
);

   // Working remainder is one bit wider than the divisor (shift-in headroom)
   localparam int W_REM = W_DVS + 1;
   localparam int W_CNT = $clog2(W_DVD + 1);

   logic [W_DVS-1:0] rem_q, rem_d;
   logic [W_DVD-1:0] quo_q, quo_d;
   logic [W_DVS-1:0] dvs_q, dvs_d;
   logic [W_CNT-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [W_REM-1:0] rem_sh;
   logic [W_REM-1:0] rem_sub;
   logic             cabe;

   // One restoring step: shift in next dividend bit, subtract if it fits
   always_comb begin
      rem_sh  = {rem_q, quo_q[W_DVD-1]};
      cabe    = (rem_sh >= W_REM'(dvs_q));
      rem_sub = rem_sh - W_REM'(dvs_q);

      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;

      if (start) begin
         rem_d  = '0;
         quo_d  = dividendo;
         dvs_d  = divisor;
         cnt_d  = W_CNT'(W_DVD);
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d = cabe ? W_DVS'(rem_sub) : W_DVS'(rem_sh);
         quo_d = {quo_q[W_DVD-2:0], cabe};
         cnt_d = cnt_q - W_CNT'(1);
         if (cnt_q == W_CNT'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // Divider state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quociente = quo_q;

endmodule

`default_nettype wire

// File: rtl/defuzzificador_it2.sv
`default_nettype none
// ============================================================================
//  Module   : defuzzificador_it2
//  Brief    : Interval type-2 output stage. Nie-Tan type reduction and
//             centroid defuzzification of three rules:
//             y = sum(Ci*(UPi+LOWi)) / sum(UPi+LOWi), one request in flight,
//             fixed latency (3 accumulate cycles + 19-bit serial division).
//  Options  : DEFUZ_ARREDONDA_EN - round to nearest instead of truncating.
//  Revision : 1.0 - initial release
// ============================================================================
module defuzzificador_it2
   import fuzzy_pkg::*;
#(
   parameter logic [W_MF-1:0] C1           = C1_PADRAO,
   parameter logic [W_MF-1:0] C2           = C2_PADRAO,
   parameter logic [W_MF-1:0] C3           = C3_PADRAO,
   parameter logic [W_MF-1:0] SAIDA_PADRAO = SAIDA_PADRAO_DEF
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            inicio,
   input  logic [W_MF-1:0] F_01_UP,
   input  logic [W_MF-1:0] F_01_LOW,
   input  logic [W_MF-1:0] F_02_UP,
   input  logic [W_MF-1:0] F_02_LOW,
   input  logic [W_MF-1:0] F_03_UP,
   input  logic [W_MF-1:0] F_03_LOW,
   output logic            ocupado,
   output logic [W_MF-1:0] saida,
   output logic            saida_valida,
   output logic            erro_div
);

`ifdef DEFUZ_ARREDONDA_EN
   // One spare bit so the rounding bias can never wrap the numerator
   localparam int W_NUM_ACC = W_NUM + 1;
`else
   localparam int W_NUM_ACC = W_NUM;
`endif
   localparam int W_S    = W_MF + 1;
   localparam int W_PROD = W_MF + W_S;

   defuz_estado_t          estado_q, estado_d;
   logic [1:0]             idx_q, idx_d;
   logic [2:0][W_MF-1:0]   up_q, up_d;
   logic [2:0][W_MF-1:0]   low_q, low_d;
   logic [W_NUM_ACC-1:0]   num_q, num_d;
   logic [W_DEN-1:0]       den_q, den_d;
   logic [W_MF-1:0]        saida_q, saida_d;
   logic                   valida_q, valida_d;
   logic                   erro_q, erro_d;
   logic                   ocupado_q, ocupado_d;
`ifdef DEFUZ_ARREDONDA_EN
   logic                   ovf_q, ovf_d;
   logic [W_NUM_ACC-1:0]   num_arred;
`endif

   logic [W_MF-1:0]        c_sel;
   logic [W_S-1:0]         soma;
   logic [W_PROD-1:0]      prod;
   logic [W_NUM_ACC-1:0]   num_inc;
   logic [W_DEN-1:0]       den_inc;
   logic [W_NUM-1:0]       div_dvd;
   logic                   div_start;
   logic                   div_busy;
   logic                   div_done;
   logic [W_NUM-1:0]       div_quo;

   // Per-rule term: select rule idx, form UP+LOW and its centroid product
   always_comb begin
      case (idx_q)
         2'd0:    begin c_sel = C1; soma = W_S'(up_q[0]) + W_S'(low_q[0]); end
         2'd1:    begin c_sel = C2; soma = W_S'(up_q[1]) + W_S'(low_q[1]); end
         default: begin c_sel = C3; soma = W_S'(up_q[2]) + W_S'(low_q[2]); end
      endcase
      prod    = W_PROD'(c_sel) * W_PROD'(soma);
      num_inc = num_q + W_NUM_ACC'(prod);
      den_inc = den_q + W_DEN'(soma);
`ifdef DEFUZ_ARREDONDA_EN
      num_arred = num_inc + W_NUM_ACC'(den_inc >> 1);
      div_dvd   = W_NUM'(num_arred);
`else
      div_dvd   = num_inc;
`endif
      // Divider loads the final sums on the same edge that leaves ACUM
      div_start = (estado_q == ACUM) && (idx_q == 2'd2);
   end

   // Control FSM next-state and registered-output logic
   always_comb begin
      estado_d  = estado_q;
      idx_d     = idx_q;
      up_d      = up_q;
      low_d     = low_q;
      num_d     = num_q;
      den_d     = den_q;
      saida_d   = saida_q;
      valida_d  = 1'b0;
      erro_d    = erro_q;
      ocupado_d = ocupado_q;
`ifdef DEFUZ_ARREDONDA_EN
      ovf_d     = ovf_q;
`endif
      case (estado_q)
         OCIOSO: begin
            if (inicio) begin
               up_d      = {F_03_UP,  F_02_UP,  F_01_UP};
               low_d     = {F_03_LOW, F_02_LOW, F_01_LOW};
               num_d     = '0;
               den_d     = '0;
               idx_d     = 2'd0;
               ocupado_d = 1'b1;
               estado_d  = ACUM;
            end
         end
         ACUM: begin
            num_d = num_inc;
            den_d = den_inc;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd2) begin
`ifdef DEFUZ_ARREDONDA_EN
               ovf_d = num_arred[W_NUM];
`endif
               estado_d = DIVIDE;
            end
         end
         DIVIDE: begin
            if (div_done && !div_busy) begin
               if (den_q == '0) begin
                  // Zero denominator follows the same timing path
                  saida_d = SAIDA_PADRAO;
                  erro_d  = 1'b1;
               end else begin
`ifdef DEFUZ_ARREDONDA_EN
                  saida_d = (ovf_q || (div_quo > W_NUM'(255))) ? '1 : W_MF'(div_quo);
`else
                  saida_d = W_MF'(div_quo);
`endif
                  erro_d  = 1'b0;
               end
               valida_d  = 1'b1;
               ocupado_d = 1'b0;
               estado_d  = FIM;
            end
         end
         FIM: begin
            // Spacer cycle; a new request is only sampled back in OCIOSO
            estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q  <= OCIOSO;
         idx_q     <= 2'd0;
         up_q      <= '0;
         low_q     <= '0;
         num_q     <= '0;
         den_q     <= '0;
         saida_q   <= '0;
         valida_q  <= 1'b0;
         erro_q    <= 1'b0;
         ocupado_q <= 1'b0;
`ifdef DEFUZ_ARREDONDA_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         estado_q  <= estado_d;
         idx_q     <= idx_d;
         up_q      <= up_d;
         low_q     <= low_d;
         num_q     <= num_d;
         den_q     <= den_d;
         saida_q   <= saida_d;
         valida_q  <= valida_d;
         erro_q    <= erro_d;
         ocupado_q <= ocupado_d;
`ifdef DEFUZ_ARREDONDA_EN
         ovf_q     <= ovf_d;
`endif
      end
   end

   divisor_serial #(
      .W_DVD (W_NUM),
      .W_DVS (W_DEN)
   ) u_divisor (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .dividendo (div_dvd),
      .divisor   (den_inc),
      .busy      (div_busy),
      .done      (div_done),
      .quociente (div_quo)
   );

   assign ocupado      = ocupado_q;
   assign saida        = saida_q;
   assign saida_valida = valida_q;
   assign erro_div     = erro_q;

endmodule

`default_nettype wire

// File: tb/tb_defuzzificador_it2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_defuzzificador_it2
//  Brief    : Scoreboard bench for defuzzificador_it2. Directed vectors carry
//             hand-computed floor and rounded results; a monitor pops the
//             expected queue on every saida_valida pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_defuzzificador_it2;

   typedef struct {
      logic [7:0] u1, l1, u2, l2, u3, l3;
      logic [7:0] flr;
      logic [7:0] rnd;
      logic       err;
      string      nome;
   } vec_t;

   typedef struct {
      logic [7:0] saida;
      logic       erro;
      int         cap;
      string      nome;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       inicio;
   logic [7:0] f1u, f1l, f2u, f2l, f3u, f3l;
   logic       ocupado;
   logic [7:0] saida;
   logic       saida_valida;
   logic       erro_div;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb[$];
   vec_t vt[$];

   defuzzificador_it2 dut (
      .clk          (clk),
      .rst          (rst),
      .inicio       (inicio),
      .F_01_UP      (f1u),
      .F_01_LOW     (f1l),
      .F_02_UP      (f2u),
      .F_02_LOW     (f2l),
      .F_03_UP      (f3u),
      .F_03_LOW     (f3l),
      .ocupado      (ocupado),
      .saida        (saida),
      .saida_valida (saida_valida),
      .erro_div     (erro_div)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(input int a, b, c, d, e, f, fl, rn, er, input string nm);
      vec_t v;
      v.u1 = 8'(a); v.l1 = 8'(b); v.u2 = 8'(c); v.l2 = 8'(d); v.u3 = 8'(e); v.l3 = 8'(f);
      v.flr = 8'(fl); v.rnd = 8'(rn); v.err = 1'(er); v.nome = nm;
      return v;
   endfunction

   task automatic chk(input string nome, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, act, req, $time);
      end
   endtask

   task automatic push_exp(input vec_t v);
      exp_t e;
`ifdef DEFUZ_ARREDONDA_EN
      e.saida = v.rnd;
`else
      e.saida = v.flr;
`endif
      e.erro = v.err;
      e.cap  = cyc + 1;
      e.nome = v.nome;
      sb.push_back(e);
   endtask

   task automatic drive_in(input vec_t v);
      f1u = v.u1; f1l = v.l1; f2u = v.u2; f2l = v.l2; f3u = v.u3; f3l = v.l3;
   endtask

   // Wait (bounded) until every expected result has been seen, then two
   // more cycles so the DUT is back in its idle state
   task automatic wait_idle();
      int t = 0;
      bool_loop: while (sb.size() != 0) begin
         if (t >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
            break;
         end
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
   endtask

   // One-cycle request pulse; inputs are scrambled right after capture
   task automatic send(input vec_t v);
      drive_in(v);
      inicio = 1'b1;
      push_exp(v);
      @(negedge clk);
      chk({"ocupado_after_capture_", v.nome}, int'(ocupado), 1);
      inicio = 1'b0;
      f1u = 8'($urandom); f1l = 8'($urandom); f2u = 8'($urandom);
      f2l = 8'($urandom); f3u = 8'($urandom); f3l = 8'($urandom);
   endtask

   // Monitor: compare each presented result against the scoreboard head
   initial begin : monitor
      logic       prev_v;
      logic [7:0] prev_s;
      exp_t       e;
      prev_v = 1'b0;
      prev_s = '0;
      forever begin
         @(posedge clk);
         #1;
         if (prev_v) begin
            chk("valid_pulse_width", int'(saida_valida), 0);
            chk("saida_hold", int'(saida), int'(prev_s));
         end
         prev_v = 1'b0;
         if (saida_valida === 1'b1) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_valid: got saida_valida=1 saida=%0d, expected no result", saida);
            end else begin
               e = sb.pop_front();
               chk({"saida_", e.nome}, int'(saida), int'(e.saida));
               chk({"erro_", e.nome}, int'(erro_div), int'(e.erro));
               chk({"latency_", e.nome}, cyc - e.cap, 23);
            end
            prev_v = 1'b1;
            prev_s = saida;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "time limit reached");
   end

   initial begin : stim
      vec_t vr;
      vt.push_back(mk(255, 255,   0,   0,   0,   0,  32,  32, 0, "r1_full"));
      vt.push_back(mk(255, 255,   0,   0, 255, 255, 128, 128, 0, "r1_r3_full"));
      vt.push_back(mk(  0,   0,   0,   0,   0,   0, 128, 128, 1, "all_zero"));
      vt.push_back(mk(  1,   0,   0,   0,   4,   0, 185, 186, 0, "num928_den5"));
      vt.push_back(mk(  0,   0,  10,  20,   0,   0, 128, 128, 0, "r2_only"));
      vt.push_back(mk(  3,   0,   0,   2,   0,   0,  70,  70, 0, "num352_den5"));
      vt.push_back(mk(  0,   0,   1,   0,   1,   0, 176, 176, 0, "r2_r3_unit"));
      vt.push_back(mk(255, 255, 255, 255, 255, 255, 128, 128, 0, "all_max"));
      vt.push_back(mk(  0,   0,   0,   0, 255, 255, 224, 224, 0, "r3_full"));
      vt.push_back(mk(  0,   0,   1,   0,   4,   0, 204, 205, 0, "num1024_den5"));
      vt.push_back(mk(  1,   0,   1,   0,   0,   0,  80,  80, 0, "r1_r2_unit"));

      rst = 1'b1; inicio = 1'b0;
      f1u = '0; f1l = '0; f2u = '0; f2l = '0; f3u = '0; f3l = '0;
      repeat (3) @(negedge clk);
      chk("reset_ocupado", int'(ocupado), 0);
      chk("reset_saida", int'(saida), 0);
      chk("reset_valida", int'(saida_valida), 0);
      chk("reset_erro", int'(erro_div), 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors, one request at a time
      foreach (vt[i]) begin
         send(vt[i]);
         wait_idle();
      end

      // inicio held high with inputs changing every cycle: captures only
      // happen in idle, 25 cycles apart, each with that edge's inputs
      for (int k = 0; k < 75; k++) begin
         vr = vt[k % 4];
         drive_in(vr);
         inicio = 1'b1;
         if (k % 25 == 0) push_exp(vr);
         @(negedge clk);
      end
      inicio = 1'b0;
      wait_idle();

      // Reset in the middle of a request aborts it without a result
      send(vt[0]);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      chk("midreset_ocupado", int'(ocupado), 0);
      chk("midreset_saida", int'(saida), 0);
      chk("midreset_valida", int'(saida_valida), 0);
      repeat (30) @(negedge clk);

      // A following request completes normally
      send(vt[3]);
      wait_idle();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
